pipe_ctrl: RTL and testbench

- Central pipeline sequencing controller for the 5-stage MIPS core; drives the per-stage stall vector consumed by the pc, if_id, id_ex, ex_mem and mem_wb pipeline registers, plus the pipeline flush.
- Merges per-stage stall requests and tracks multi-cycle EX operations (mult-accumulate, div) with an internal busy counter.
- Sequences exception/redirect flushes and keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges per-stage stall requests, holds EX for
// multi-cycle ops, drives registered flush/redirect, and counts stalled cycles.
module pipe_ctrl #(
  parameter int MC_CNT_W  = 6,
  parameter int FLUSH_LEN = 1,
  parameter int PERF_W    = 32,
  parameter int REG_W     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_from_if,
  input  logic                stallreq_from_id,
  input  logic                stallreq_from_ex,
  input  logic                stallreq_from_mem,
  input  logic                ex_mc_start,
  input  logic [MC_CNT_W-1:0] ex_mc_cycles,
  input  logic                flush_req,
  input  logic [REG_W-1:0]    flush_pc,
  output logic [5:0]          stall,
  output logic                flush,
  output logic [REG_W-1:0]    new_pc,
  output logic                ex_mc_done,
  output logic                mc_busy,
  output logic [PERF_W-1:0]   stall_cycles
);

  typedef enum logic [1:0] {RUN = 2'd0, MC = 2'd1, FLUSH = 2'd2} state_e;

  state_e              state_q, state_d;
  logic [MC_CNT_W-1:0] mc_cnt_q, mc_cnt_d;
  logic [2:0]          flush_cnt_q, flush_cnt_d;
  logic                flush_q, flush_d;
  logic [REG_W-1:0]    new_pc_q, new_pc_d;
  logic [PERF_W-1:0]   stall_cycles_q, stall_cycles_d;
  logic                mc_start_ok;
  logic                mc_hold;

  assign mc_start_ok = ex_mc_start && (ex_mc_cycles >= MC_CNT_W'(2));
  assign mc_hold     = ((state_q == RUN) && mc_start_ok) ||
                       ((state_q == MC) && (mc_cnt_q > MC_CNT_W'(1)));

  always_comb begin
    stall = 6'b000000;
    if (!rst && state_q != FLUSH) begin
      if (stallreq_from_mem)                 stall = 6'b011111;
      else if (stallreq_from_ex || mc_hold)  stall = 6'b001111;
      else if (stallreq_from_id)             stall = 6'b000111;
      else if (stallreq_from_if)             stall = 6'b000011;
    end
  end

  always_comb begin
    state_d        = state_q;
    mc_cnt_d       = mc_cnt_q;
    flush_cnt_d    = flush_cnt_q;
    flush_d        = flush_q;
    new_pc_d       = new_pc_q;
    stall_cycles_d = stall_cycles_q;
    case (state_q)
      RUN: begin
        if (mc_start_ok) begin
          state_d  = MC;
          mc_cnt_d = ex_mc_cycles - MC_CNT_W'(1);
        end
      end
      MC: begin
        if (mc_cnt_q > MC_CNT_W'(1)) begin
          mc_cnt_d = mc_cnt_q - MC_CNT_W'(1);
        end else begin
          state_d  = RUN;
          mc_cnt_d = '0;
        end
      end
      FLUSH: begin
        if (flush_cnt_q != 3'd0) begin
          flush_cnt_d = flush_cnt_q - 3'd1;
        end else begin
          flush_d = 1'b0;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    // A redirect overrides everything, including an in-flight multi-cycle op.
    if (flush_req) begin
      state_d     = FLUSH;
      new_pc_d    = flush_pc;
      flush_d     = 1'b1;
      flush_cnt_d = 3'(FLUSH_LEN - 1);
      mc_cnt_d    = '0;
    end
    if (stall[0] && !(&stall_cycles_q)) stall_cycles_d = stall_cycles_q + PERF_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      mc_cnt_q       <= '0;
      flush_cnt_q    <= 3'd0;
      flush_q        <= 1'b0;
      new_pc_q       <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      mc_cnt_q       <= mc_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
      flush_q        <= flush_d;
      new_pc_q       <= new_pc_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign flush        = flush_q;
  assign new_pc       = new_pc_q;
  assign stall_cycles = stall_cycles_q;
  assign mc_busy      = (state_q == MC);
  assign ex_mc_done   = !rst && (state_q == MC) && (mc_cnt_q == MC_CNT_W'(1));

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: priority table plus multi-cycle, flush,
// back-to-back flush, reset-abort and saturating counter sequences.
module tb_pipe_ctrl;
  localparam int MC_CNT_W = 6, FLUSH_LEN = 2, PERF_W = 4, REG_W = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic                sr_if, sr_id, sr_ex, sr_mem;
  logic                ex_mc_start;
  logic [MC_CNT_W-1:0] ex_mc_cycles;
  logic                flush_req;
  logic [REG_W-1:0]    flush_pc;
  logic [5:0]          stall;
  logic                flush, ex_mc_done, mc_busy;
  logic [REG_W-1:0]    new_pc;
  logic [PERF_W-1:0]   stall_cycles;

  int checks = 0, errors = 0;

  pipe_ctrl #(.MC_CNT_W(MC_CNT_W), .FLUSH_LEN(FLUSH_LEN), .PERF_W(PERF_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst),
    .stallreq_from_if(sr_if), .stallreq_from_id(sr_id),
    .stallreq_from_ex(sr_ex), .stallreq_from_mem(sr_mem),
    .ex_mc_start(ex_mc_start), .ex_mc_cycles(ex_mc_cycles),
    .flush_req(flush_req), .flush_pc(flush_pc),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .ex_mc_done(ex_mc_done), .mc_busy(mc_busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r_if, r_id, r_ex, r_mem;
    logic       mc_start;
    logic [5:0] mc_cycles;
    logic [5:0] exp_stall;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to the next cycle: inputs are driven just after the edge.
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle();
    sr_if = 0; sr_id = 0; sr_ex = 0; sr_mem = 0;
    ex_mc_start = 0; ex_mc_cycles = '0; flush_req = 0; flush_pc = '0;
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{0,0,0,0, 0,6'd0, 6'b000000};
    vecs[1]  = '{1,0,0,0, 0,6'd0, 6'b000011};
    vecs[2]  = '{0,1,0,0, 0,6'd0, 6'b000111};
    vecs[3]  = '{0,0,1,0, 0,6'd0, 6'b001111};
    vecs[4]  = '{0,0,0,1, 0,6'd0, 6'b011111};
    vecs[5]  = '{0,1,0,1, 0,6'd0, 6'b011111};
    vecs[6]  = '{1,1,0,0, 0,6'd0, 6'b000111};
    vecs[7]  = '{1,0,1,0, 0,6'd0, 6'b001111};
    vecs[8]  = '{1,1,1,1, 0,6'd0, 6'b011111};
    vecs[9]  = '{0,0,0,0, 1,6'd1, 6'b000000};
    vecs[10] = '{0,0,0,0, 1,6'd0, 6'b000000};

    // Reset with every request asserted
    idle();
    rst = 1; sr_if = 1; sr_id = 1; sr_ex = 1; sr_mem = 1;
    ex_mc_start = 1; ex_mc_cycles = 6'd5; flush_req = 1; flush_pc = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      cyc(); settle();
      chk("rst_stall", stall, 6'b000000);
      chk("rst_done", ex_mc_done, 0);
      chk("rst_flush", flush, 0);
      chk("rst_new_pc", new_pc, 0);
      chk("rst_perf", stall_cycles, 0);
    end
    idle(); rst = 0;
    cyc(); settle();
    chk("post_rst_busy", mc_busy, 0);

    // Priority table from RUN (N<2 starts must not hold or enter MC)
    for (int i = 0; i < 11; i++) begin
      sr_if = vecs[i].r_if; sr_id = vecs[i].r_id; sr_ex = vecs[i].r_ex; sr_mem = vecs[i].r_mem;
      ex_mc_start = vecs[i].mc_start; ex_mc_cycles = vecs[i].mc_cycles;
      settle();
      chk($sformatf("tbl%0d_stall", i), stall, vecs[i].exp_stall);
      chk($sformatf("tbl%0d_done", i), ex_mc_done, 0);
      cyc(); idle(); settle();
      chk($sformatf("tbl%0d_busy", i), mc_busy, 0);
    end

    // Multi-cycle N=4: hold in rel cycles 0..2, done in 3, busy 1..3
    idle(); ex_mc_start = 1; ex_mc_cycles = 6'd4; settle();
    chk("mc4_c0_stall", stall, 6'b001111);
    chk("mc4_c0_busy", mc_busy, 0);
    for (int c = 1; c <= 4; c++) begin
      cyc(); idle(); settle();
      chk($sformatf("mc4_c%0d_stall", c), stall, (c <= 2) ? 6'b001111 : 6'b000000);
      chk($sformatf("mc4_c%0d_done", c), ex_mc_done, c == 3);
      chk($sformatf("mc4_c%0d_busy", c), mc_busy, c <= 3);
    end

    // Multi-cycle N=3 with a MEM request mid-op: priority ORs, timing unchanged
    ex_mc_start = 1; ex_mc_cycles = 6'd3; settle();
    cyc(); idle(); sr_mem = 1; settle();
    chk("mc3_mem_stall", stall, 6'b011111);
    cyc(); idle(); settle();
    chk("mc3_done", ex_mc_done, 1);
    chk("mc3_done_stall", stall, 6'b000000);
    cyc(); settle();
    chk("mc3_end_busy", mc_busy, 0);

    // Flush mid-MC: N=8 at rel 0, flush_req at rel 2
    begin
      logic saw_done;
      saw_done = 0;
      ex_mc_start = 1; ex_mc_cycles = 6'd8; settle();
      cyc(); idle(); settle();
      saw_done |= ex_mc_done;
      cyc(); idle(); flush_req = 1; flush_pc = 32'h0000_0120; settle();
      chk("fmc_req_stall", stall, 6'b001111);
      saw_done |= ex_mc_done;
      for (int c = 3; c <= 4; c++) begin
        cyc(); idle(); sr_mem = 1; settle();
        chk($sformatf("fmc_c%0d_flush", c), flush, 1);
        chk($sformatf("fmc_c%0d_pc", c), new_pc, 32'h120);
        chk($sformatf("fmc_c%0d_stall", c), stall, 6'b000000);
        chk($sformatf("fmc_c%0d_busy", c), mc_busy, 0);
        saw_done |= ex_mc_done;
      end
      cyc(); idle(); sr_id = 1; settle();
      chk("fmc_end_flush", flush, 0);
      chk("fmc_end_run_stall", stall, 6'b000111);
      for (int c = 0; c < 8; c++) begin
        saw_done |= ex_mc_done;
        cyc(); idle(); settle();
      end
      chk("fmc_no_done", saw_done, 0);
    end

    // Back-to-back flush: rel 0 pc 0x40, rel 1 pc 0x80; flush high rel 1..3
    idle(); flush_req = 1; flush_pc = 32'h40; settle();
    chk("bb_c0_flush", flush, 0);
    cyc(); idle(); flush_req = 1; flush_pc = 32'h80; settle();
    chk("bb_c1_flush", flush, 1);
    chk("bb_c1_pc", new_pc, 32'h40);
    for (int c = 2; c <= 4; c++) begin
      cyc(); idle(); settle();
      chk($sformatf("bb_c%0d_flush", c), flush, c <= 3);
      chk($sformatf("bb_c%0d_pc", c), new_pc, 32'h80);
    end

    // Reset mid-MC aborts with no done pulse
    ex_mc_start = 1; ex_mc_cycles = 6'd3; settle();
    cyc(); idle(); rst = 1; settle();
    chk("rmc_rst_done", ex_mc_done, 0);
    chk("rmc_rst_stall", stall, 6'b000000);
    cyc(); rst = 0; settle();
    chk("rmc_busy", mc_busy, 0);
    chk("rmc_done", ex_mc_done, 0);
    chk("rmc_perf_clr", stall_cycles, 0);

    // Saturating stall-cycle counter
    idle(); sr_id = 1;
    for (int c = 1; c <= 20; c++) begin
      cyc(); settle();
      if (c == 5)  chk("perf_5", stall_cycles, 5);
      if (c == 15) chk("perf_15", stall_cycles, 15);
      if (c == 20) chk("perf_sat", stall_cycles, 15);
    end
    idle(); rst = 1;
    cyc(); rst = 0; settle();
    chk("perf_rst", stall_cycles, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
